// File: rtl/fx_mult_seq.sv
// Sequential sign-magnitude fixed-point multiplier: one multiplier bit per cycle,
// with a valid/ready handshake on both sides and optional rounding and saturation.
module fx_mult_seq #(
  parameter int unsigned Q        = 15,
  parameter int unsigned N        = 32,
  parameter bit          SATURATE = 1'b1,
  parameter bit          ROUND    = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [N-1:0] multiplicand_i,
  input  logic [N-1:0] multiplier_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [N-1:0] result_o,
  output logic         overflow_o
);

  localparam int unsigned MW = N - 1;
  localparam int unsigned PW = 2 * N - 2;
  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t        state, state_d;
  logic [PW-1:0] acc;
  logic [PW-1:0] mcand;
  logic [MW-1:0] mplr;
  logic [CW-1:0] cnt;
  logic          sign;

  logic [MW-1:0] m_base_c;
  logic          rnd_c;
  logic [N-1:0]  m_sum_c;
  logic          ovf_c;
  logic [MW-1:0] mag_c;

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (valid_i) state_d = MUL;
      MUL:     if (cnt == '0) state_d = DONE;
      DONE:    if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Round bit exists only when there are fractional bits to round away
  if (ROUND && (Q > 0)) begin : g_rnd
    assign rnd_c = acc[Q-1];
  end else begin : g_nornd
    assign rnd_c = 1'b0;
  end

  // Result formatting from the finished product
  always_comb begin
    m_base_c = MW'(acc >> Q);
    m_sum_c  = {1'b0, m_base_c} + N'(rnd_c);
    ovf_c    = (|(acc >> (MW + Q))) | m_sum_c[N-1];
    mag_c    = (ovf_c && SATURATE) ? {MW{1'b1}} : m_sum_c[MW-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      ready_o    <= 1'b1;
      valid_o    <= 1'b0;
      result_o   <= '0;
      overflow_o <= 1'b0;
      acc        <= '0;
      mcand      <= '0;
      mplr       <= '0;
      cnt        <= '0;
      sign       <= 1'b0;
    end else begin
      state   <= state_d;
      ready_o <= (state_d == IDLE);
      valid_o <= (state_d == DONE);
      case (state)
        IDLE: begin
          if (valid_i) begin
            mcand <= PW'(multiplicand_i[MW-1:0]);
            mplr  <= multiplier_i[MW-1:0];
            sign  <= multiplicand_i[N-1] ^ multiplier_i[N-1];
            acc   <= '0;
            cnt   <= CW'(MW);
          end
        end
        MUL: begin
          if (cnt != '0) begin
            if (mplr[0]) acc <= acc + mcand;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            cnt   <= cnt - CW'(1);
          end else begin
            // A zero magnitude never carries a negative sign
            result_o   <= {sign & (|mag_c), mag_c};
            overflow_o <= ovf_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fx_mult_seq.md
FX_MULT_SEQ -- requirements
Module: fx_mult_seq

Interface
REQ-001 Parameter Q, default 15: fractional bits of operands and result; legal range 0 <= Q <= N-2.
REQ-002 Parameter N, default 32: total word width, sign-magnitude (bit N-1 = sign, bits N-2:0 = magnitude); legal N >= 4.
REQ-003 Parameter SATURATE, default 1: 1 = clamp magnitude on overflow; 0 = wrap (keep low N-1 magnitude bits).
REQ-004 Parameter ROUND, default 0: 0 = truncate; 1 = round half-up on magnitude (adds product bit Q-1; no effect when Q = 0).
REQ-005 clk_i  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-007 valid_i  input  1  operand pair valid.
REQ-008 ready_o  output  1  block can accept operands.
REQ-009 multiplicand_i  input  N  sign-magnitude operand A.
REQ-010 multiplier_i  input  N  sign-magnitude operand B.
REQ-011 valid_o  output  1  result_o/overflow_o valid.
REQ-012 ready_i  input  1  downstream accepts result.
REQ-013 result_o  output  N  sign-magnitude product, same Q as inputs.
REQ-014 overflow_o  output  1  product magnitude exceeded N-1 bits; qualified by valid_o.

Function
REQ-015 FSM states IDLE, MUL, DONE; ready_o = 1 only in IDLE; valid_o = 1 only in DONE.
REQ-016 IDLE: on valid_i && ready_o at edge E0, latch both operands, clear (2N-2)-bit magnitude accumulator, load iteration counter, go MUL.
REQ-017 MUL: one multiplier magnitude bit per cycle, LSB first, shift-add into accumulator; exactly N-1 cycles (edges E1..E(N-1)).
REQ-018 At edge EN, load result_o/overflow_o registers and go DONE; latency from accept edge to valid_o high = N cycles (N = 32: 32 cycles).
REQ-019 DONE: result_o, overflow_o held stable while ready_i = 0; on ready_i = 1 go IDLE at that edge; valid_i ignored in MUL and DONE.
REQ-020 Throughput: at most one operation per N+1 cycles; no back-to-back acceptance in the DONE->IDLE edge.
REQ-021 Magnitude P = |A| * |B| (2N-2 bits); base result magnitude M = P[N-2+Q:Q], plus P[Q-1] when ROUND = 1 and Q > 0.
REQ-022 overflow_o = 1 when P[2N-3:N-1+Q] is nonzero or rounding carries out of bit N-2; else 0.
REQ-023 On overflow: SATURATE = 1 -> magnitude = all ones (N-1 bits); SATURATE = 0 -> low N-1 bits of M.
REQ-024 Sign = A[N-1] XOR B[N-1], except sign forced 0 when final magnitude is zero (no negative zero output).
REQ-025 Operand inputs sampled only at accept edge; changes afterwards do not affect the in-flight result.

Reset
REQ-026 rst_n_i low asynchronously forces IDLE, ready_o = 1, valid_o = 0, result_o = 0, overflow_o = 0, accumulator and counter = 0.
REQ-027 Reset asserted mid-MUL or in DONE aborts the operation; no valid_o pulse follows reset release without a new accept.
REQ-028 First accept possible at the first rising edge with rst_n_i high.

Verification (N = 32, Q = 15 unless stated)
REQ-029 Basic: A = 0x0000C000 (1.5), B = 0x00010000 (2.0) -> after 32 cycles valid_o = 1, result_o = 0x00018000, overflow_o = 0.
REQ-030 Sign/zero: A = 0x8000C000, B = 0x00010000 -> 0x80018000; A = 0x80000000, B = 0x00008000 -> 0x00000000 (sign cleared).
REQ-031 Overflow: A = 0x40000000, B = 0x00010000 -> overflow_o = 1; SATURATE = 1 -> 0x7FFFFFFF; SATURATE = 0 -> 0x00000000.
REQ-032 Rounding: A = 0x00000001, B = 0x00004000 -> ROUND = 0 -> 0x00000000; ROUND = 1 -> 0x00000001.
REQ-033 Backpressure: ready_i held 0 for 5 cycles in DONE -> result_o stable, ready_o = 0, valid_i pulses ignored; ready_i = 1 -> IDLE next edge, ready_o = 1.
REQ-034 Reset mid-op: rst_n_i low at cycle 10 of MUL -> all outputs at reset values immediately; after release no valid_o until a new accept.
